comp_status_debouncer: RTL
==========================

Name: comp_status_debouncer

Overview:
- Upstream stage of the computer-occupancy display decoder.
- Takes the raw, asynchronous per-computer status lines from the lab benches.
- Synchronises and debounces each line, then presents a clean registered 5-bit `comps` vector that feeds the seven-segment occupancy decoder directly.
- Also emits a one-cycle change strobe and a busy count for logging.

Parameters:
- N_COMPS, 5, number of computer status lines (width of raw_comps/comps).
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-bit debounce counter (derived; not overridden).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- raw_comps  input  N_COMPS  asynchronous status lines; bit=0 means computer busy, bit=1 means free.
- comps  output  N_COMPS  debounced, registered status vector (same encoding); drives the decoder's comps input.
- changed  output  1  one-cycle pulse, high in the cycle after at least one comps bit updated.
- busy_count  output  3  number of 0 bits in comps (0..5), combinational from registered comps.

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `rst` is synchronous and active-high.
  - All state updates on rising `clk` only.
- Reset values (rst high at an edge):
  - sync stages = all 1s.
  - comps = 5'b11111 (all free).
  - counters = 0.
  - changed = 0.
  - busy_count therefore = 0.
- Synchroniser:
  - Two flops per bit: sync1 <= raw_comps, then sync2 <= sync1.
  - No logic between the two stages.
- Per-bit debounce, evaluated every edge with rst low:
  - If sync2[i] == comps[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: comps[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency:
  - A raw level first sampled at edge k (into sync1) and held stable reaches comps at edge k+DEBOUNCE_CYCLES+1.
  - With the default DEBOUNCE_CYCLES=4, that is edge k+5.
- Glitch rejection:
  - Any excursion shorter than DEBOUNCE_CYCLES consecutive sync2 cycles clears cnt[i] on return.
  - comps[i] does not change.
  - The counter restarts from 0 on the next excursion; there is no accumulation.
- DEBOUNCE_CYCLES=1:
  - comps[i] updates on the first edge at which sync2[i] differs.
  - Counter stays 0.
- Independence and simultaneous updates:
  - Bits are debounced independently.
  - Several bits may update on the same edge.
  - changed is a single pulse regardless of how many bits updated.
- changed:
  - changed <= OR over i of (bit i updates at this edge).
  - High for exactly one cycle per update edge.
  - Back-to-back update edges give changed high on consecutive cycles.
- busy_count:
  - Popcount of ~comps.
  - Never exceeds N_COMPS.
  - 3 bits wide for N_COMPS=5.
- Reset mid-debounce:
  - In-progress counts are discarded.
  - comps forced to all 1s.
  - No changed pulse is generated by reset entry or exit.
  - After reset release, a raw level still held low requires the full latency again.
- No handshake: the downstream decoder samples comps continuously.

Decomposition:
- Shared package comp_status_pkg:
  - N_COMPS_DEF=5.
  - COMP_FREE=1'b1 and COMP_BUSY=1'b0.
  - DEBOUNCE_DEF=4.
  - Typedef comp_vec_t, a logic vector of N_COMPS_DEF bits.
- Sub-module comp_debounce_bit:
  - Contains the 2-flop sync, counter and output flop for one line, plus an `upd` output.
  - Instantiated N_COMPS times by a generate loop.
  - The top ORs the `upd` outputs into changed and computes busy_count.

Test Plan:
1. Reset check: hold rst=1 for 3 cycles with raw_comps=5'b00000 -> comps=5'b11111, changed=0, busy_count=0 throughout reset and on the first cycle after release.
2. Stable change: after reset, drive raw_comps=5'b11110 before edge k -> comps=5'b11110 at edge k+5, changed=1 for exactly that one cycle, busy_count=1.
3. Glitch rejection: drive raw_comps[2]=0 for 3 cycles, then back to 1 -> comps stays 5'b11111, changed never asserts.
4. Simultaneous bits: switch raw_comps from 5'b11111 to 5'b01010 in one step -> all three bits update on the same edge (k+5), comps=5'b01010, single changed pulse, busy_count=3.
5. Reset mid-operation: start 5'b11111 -> 5'b00000, assert rst at edge k+3 for 1 cycle, keep raw at 5'b00000 -> comps=5'b11111 until edge rel+6 (rel = release edge), then comps=5'b00000, busy_count=5.
6. DEBOUNCE_CYCLES=1 instance: raw_comps=5'b10111 at edge k -> comps=5'b10111 at edge k+2; a 1-cycle glitch passes through, delayed by 2 cycles.

Source files
------------

// File: rtl/comp_status_pkg.sv
// Shared definitions for the computer-occupancy status path.
//   N_COMPS_DEF  : default number of computer status lines
//   DEBOUNCE_DEF : default number of stable synchronised cycles before a level is accepted
//   COMP_FREE / COMP_BUSY : line encoding (1 = free, 0 = busy)
//   comp_vec_t   : status vector of N_COMPS_DEF bits
package comp_status_pkg;

  localparam int unsigned N_COMPS_DEF  = 5;
  localparam int unsigned DEBOUNCE_DEF = 4;

  localparam logic COMP_FREE = 1'b1;
  localparam logic COMP_BUSY = 1'b0;

  typedef logic [N_COMPS_DEF-1:0] comp_vec_t;

endpackage

// File: rtl/comp_debounce_bit.sv
// One status line: two-flop synchroniser, persistence counter and output flop.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   raw_i   : asynchronous raw status line
//   level_o : debounced, registered level
//   upd_o   : high when level_o takes a new value at the coming clock edge
module comp_debounce_bit
  import comp_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic upd_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd;

  // The count tracks how many consecutive synchronised cycles have
  // disagreed with the accepted level; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      upd     = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= COMP_FREE;
      sync2_q <= COMP_FREE;
      level_q <= COMP_FREE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign upd_o   = upd;

endmodule

// File: rtl/comp_status_debouncer.sv
// Debounces the raw per-computer status lines into a clean registered vector
// for the seven-segment occupancy decoder, plus a change strobe and busy count.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   raw_comps  : asynchronous status lines (0 = busy, 1 = free)
//   comps      : debounced registered status vector, same encoding
//   changed    : one-cycle pulse in the cycle after any comps bit updated
//   busy_count : number of busy (0) bits in comps
module comp_status_debouncer
  import comp_status_pkg::*;
#(
  parameter int unsigned N_COMPS         = N_COMPS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_COMPS-1:0] raw_comps,
  output logic [N_COMPS-1:0] comps,
  output logic               changed,
  output logic [2:0]         busy_count
);

  logic [N_COMPS-1:0] upd;
  logic               changed_q;
  logic [2:0]         busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_COMPS); gi++) begin : g_bit
      comp_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (raw_comps[gi]),
        .level_o(comps[gi]),
        .upd_o  (upd[gi])
      );
    end
  endgenerate

  // A single strobe covers any number of bits updating on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd;
    end
  end

  assign changed = changed_q;

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < int'(N_COMPS); i++) begin
      if (comps[i] == COMP_BUSY) begin
        busy_d = busy_d + 3'd1;
      end
    end
  end

  assign busy_count = busy_d;

endmodule
